// File: rtl/uart_autobaud.sv
// Auto-baud configurator: times a 0x55 sync character on rxd and emits one
// receiver/transmitter configuration word on an AXI-Stream master.
module uart_autobaud #(
  parameter int unsigned PARITY         = 0,
  parameter int unsigned BYTE_SIZE      = 8,
  parameter int unsigned STOP_BITS      = 0,
  parameter int unsigned IDLE_CYCLES    = 64,
  parameter int unsigned TIMEOUT_CYCLES = 16777215,
  parameter int unsigned MIN_PRESCALER  = 4
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        start,
  input  logic        rxd,
  output logic [26:0] m_axis_config_tdata,
  output logic        m_axis_config_tvalid,
  input  logic        m_axis_config_tready,
  output logic        busy,
  output logic        done,
  output logic [2:0]  error,
  output logic [15:0] baud_prescaler
);

  localparam int unsigned CNT_W  = 20;
  localparam int unsigned P_W    = CNT_W + 1;
  localparam int unsigned TO_W   = 32;
  localparam int unsigned IDLE_W = (IDLE_CYCLES < 2) ? 1 : $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_WAIT_START,
    S_MEASURE,
    S_CHECK,
    S_SEND
  } state_t;

  state_t                 state, state_n;
  logic                   sync1, sync2, prev;
  logic                   fall, rise;
  logic [TO_W-1:0]        timeout_cnt, timeout_n;
  logic [IDLE_W-1:0]      idle_cnt, idle_n;
  logic [CNT_W-1:0]       period_cnt, period_n;
  logic [CNT_W-1:0]       interval_cnt, interval_n;
  logic [3:0][CNT_W-1:0]  ivl, ivl_n;
  logic [2:0]             fall_cnt, fall_n;
  logic                   rise_seen, rise_seen_n;
  logic [2:0]             error_n;
  logic [15:0]            presc_n;
  logic [26:0]            tdata_n;
  logic                   tvalid_n;
  logic                   timed, timeout_hit, pattern_bad, range_bad;
  logic [P_W-1:0]         p_wide;
  logic [CNT_W-1:0]       period_inc, interval_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  // Two-stage synchroniser plus one history flop for edge detection
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign fall = prev & ~sync2;
  assign rise = ~prev & sync2;

  assign period_inc   = sat_inc(period_cnt);
  assign interval_inc = sat_inc(interval_cnt);
  assign timed        = (state == S_WAIT_IDLE) || (state == S_WAIT_START) || (state == S_MEASURE);
  assign timeout_hit  = timed && (timeout_cnt >= TO_W'(TIMEOUT_CYCLES));
  assign p_wide       = (P_W'(period_cnt) + P_W'(4)) >> 3;
  assign range_bad    = (p_wide > P_W'(65535)) || (p_wide < P_W'(MIN_PRESCALER));

  // Intervals 2..4 must lie within a quarter of the reference interval
  always_comb begin
    pattern_bad = 1'b0;
    for (int k = 1; k < 4; k++) begin
      if (abs_diff(ivl[k], ivl[0]) > (ivl[0] >> 2)) pattern_bad = 1'b1;
    end
  end

  always_comb begin
    state_n     = state;
    timeout_n   = timeout_cnt;
    idle_n      = idle_cnt;
    period_n    = period_cnt;
    interval_n  = interval_cnt;
    ivl_n       = ivl;
    fall_n      = fall_cnt;
    rise_seen_n = rise_seen;
    error_n     = error;
    presc_n     = baud_prescaler;
    tdata_n     = m_axis_config_tdata;
    tvalid_n    = m_axis_config_tvalid;
    done        = 1'b0;

    if (timed) timeout_n = timeout_cnt + TO_W'(1);

    case (state)
      S_IDLE: begin
        if (start) begin
          error_n   = 3'b000;
          timeout_n = '0;
          idle_n    = '0;
          state_n   = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (timeout_hit) begin
          error_n[2] = 1'b1;
          state_n    = S_IDLE;
        end else if (!sync2) begin
          idle_n = '0;
        end else if ((32'(idle_cnt) + 32'd1) >= IDLE_CYCLES) begin
          state_n = S_WAIT_START;
        end else begin
          idle_n = idle_cnt + IDLE_W'(1);
        end
      end
      S_WAIT_START: begin
        if (timeout_hit) begin
          error_n[2] = 1'b1;
          state_n    = S_IDLE;
        end else if (fall) begin
          period_n    = '0;
          interval_n  = '0;
          fall_n      = 3'd1;
          rise_seen_n = 1'b0;
          state_n     = S_MEASURE;
        end
      end
      S_MEASURE: begin
        period_n   = period_inc;
        interval_n = interval_inc;
        if (timeout_hit) begin
          error_n[2] = 1'b1;
          state_n    = S_IDLE;
        end else if (rise) begin
          if (rise_seen) begin
            error_n[0] = 1'b1;
            state_n    = S_IDLE;
          end else begin
            rise_seen_n = 1'b1;
          end
        end else if (fall) begin
          if (!rise_seen) begin
            error_n[0] = 1'b1;
            state_n    = S_IDLE;
          end else begin
            // latched value counts the current cycle, so it equals the edge spacing
            ivl_n[2'(fall_cnt - 3'd1)] = interval_inc;
            interval_n  = '0;
            fall_n      = 3'(fall_cnt + 3'd1);
            rise_seen_n = 1'b0;
            if (fall_cnt == 3'd4) state_n = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (pattern_bad) begin
          error_n[0] = 1'b1;
          state_n    = S_IDLE;
        end else if (range_bad) begin
          error_n[1] = 1'b1;
          state_n    = S_IDLE;
        end else begin
          presc_n  = p_wide[15:0];
          tdata_n  = {2'b00, 1'b1, 1'(STOP_BITS), 4'(BYTE_SIZE), 3'(PARITY), p_wide[15:0]};
          tvalid_n = 1'b1;
          state_n  = S_SEND;
        end
      end
      S_SEND: begin
        if (m_axis_config_tready) begin
          tvalid_n = 1'b0;
          done     = 1'b1;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state                <= S_IDLE;
      timeout_cnt          <= '0;
      idle_cnt             <= '0;
      period_cnt           <= '0;
      interval_cnt         <= '0;
      ivl                  <= '0;
      fall_cnt             <= '0;
      rise_seen            <= 1'b0;
      error                <= '0;
      baud_prescaler       <= '0;
      m_axis_config_tdata  <= '0;
      m_axis_config_tvalid <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      state                <= state_n;
      timeout_cnt          <= timeout_n;
      idle_cnt             <= idle_n;
      period_cnt           <= period_n;
      interval_cnt         <= interval_n;
      ivl                  <= ivl_n;
      fall_cnt             <= fall_n;
      rise_seen            <= rise_seen_n;
      error                <= error_n;
      baud_prescaler       <= presc_n;
      m_axis_config_tdata  <= tdata_n;
      m_axis_config_tvalid <= tvalid_n;
      busy                 <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_autobaud.sv
// Self-checking bench for uart_autobaud: line waveforms are built as segment
// lists and an edge-timing model derives the expected error and prescaler.
module tb_uart_autobaud;

  logic        aclk = 1'b0;
  logic        areset, start, rxd, tready;
  logic [26:0] tdata;
  logic        tvalid, busy, done;
  logic [2:0]  error;
  logic [15:0] presc;

  logic        start_t, rxd_t, tready_t;
  logic [26:0] tdata_t;
  logic        tvalid_t, busy_t, done_t;
  logic [2:0]  error_t;
  logic [15:0] presc_t;

  uart_autobaud dut (
    .aclk(aclk), .areset(areset), .start(start), .rxd(rxd),
    .m_axis_config_tdata(tdata), .m_axis_config_tvalid(tvalid),
    .m_axis_config_tready(tready), .busy(busy), .done(done),
    .error(error), .baud_prescaler(presc)
  );

  uart_autobaud #(.TIMEOUT_CYCLES(1000)) dut_to (
    .aclk(aclk), .areset(areset), .start(start_t), .rxd(rxd_t),
    .m_axis_config_tdata(tdata_t), .m_axis_config_tvalid(tvalid_t),
    .m_axis_config_tready(tready_t), .busy(busy_t), .done(done_t),
    .error(error_t), .baud_prescaler(presc_t)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int seg_lvl[$];
  int seg_dur[$];

  int          hold_cycles = 0;
  int          held = 0;
  int          done_cnt = 0;
  int          stall_cnt = 0;
  int          last_good_p = 0;
  bit          was_stalled = 1'b0;
  logic [26:0] hs_tdata = '0;
  logic [26:0] last_tdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Handshake monitor on the main instance
  always @(negedge aclk) begin
    if (was_stalled && tvalid) check("tdata_stable", 32'(tdata), 32'(last_tdata));
    if (done) begin
      done_cnt++;
      hs_tdata = tdata;
      check("done_handshake", {30'b0, tvalid, tready}, 32'd3);
    end
    if (tvalid && !tready) stall_cnt++;
    was_stalled = tvalid && !tready;
    last_tdata  = tdata;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
    if (tvalid && !tready) begin
      held++;
      if (held > hold_cycles) tready = 1'b1;
    end
  endtask

  task automatic clear_segs();
    seg_lvl.delete();
    seg_dur.delete();
  endtask

  task automatic add_char(input logic [7:0] b, input int n);
    seg_lvl.push_back(0);
    seg_dur.push_back(n);
    for (int i = 0; i < 8; i++) begin
      seg_lvl.push_back(int'(b[i]));
      seg_dur.push_back(n);
    end
    seg_lvl.push_back(1);
    seg_dur.push_back(n);
  endtask

  // Shift boundary i (between segment i and i+1) by j cycles
  task automatic jitter_edge(input int i, input int j);
    seg_dur[i]   = seg_dur[i] + j;
    seg_dur[i+1] = seg_dur[i+1] - j;
  endtask

  task automatic drive_segs();
    for (int i = 0; i < seg_lvl.size(); i++) begin
      rxd = (seg_lvl[i] != 0);
      repeat (seg_dur[i]) tick();
    end
  endtask

  // Edge-timing model of the measurement rules
  function automatic void model(output logic [2:0] err, output int p);
    int t    = 0;
    int prv  = 1;
    bit rs   = 1'b0;
    int nf   = 0;
    int t0   = 0;
    int tl   = 0;
    int per  = 0;
    int d;
    int ivl[4];
    err = 3'b000;
    p   = 0;
    for (int k = 0; k < 4; k++) ivl[k] = 0;
    for (int i = 0; i < seg_lvl.size(); i++) begin
      if (seg_lvl[i] != prv && nf < 5 && err == 3'b000) begin
        if (seg_lvl[i] == 0) begin
          if (nf == 0) begin
            t0 = t; tl = t; nf = 1; rs = 1'b0;
          end else if (!rs) begin
            err = 3'b001;
          end else begin
            ivl[nf-1] = t - tl;
            tl = t;
            nf++;
            rs = 1'b0;
            if (nf == 5) per = t - t0;
          end
        end else if (nf > 0) begin
          if (rs) err = 3'b001;
          else rs = 1'b1;
        end
      end
      prv = seg_lvl[i];
      t += seg_dur[i];
    end
    if (err == 3'b000 && nf < 5) err = 3'b100;
    if (err == 3'b000) begin
      for (int k = 1; k < 4; k++) begin
        d = ivl[k] - ivl[0];
        if (d < 0) d = -d;
        if (d > ivl[0] / 4) err = 3'b001;
      end
    end
    if (err == 3'b000) begin
      p = (per + 4) / 8;
      if (p > 65535 || p < 4) err = 3'b010;
    end
  endfunction

  function automatic logic [26:0] cfg_word(input int p);
    return {2'b00, 1'b1, 1'b0, 4'd8, 3'd0, 16'(p)};
  endfunction

  task automatic run_case(input string name, input int hold);
    logic [2:0] exp_err;
    int         exp_p;
    int         k;
    done_cnt    = 0;
    stall_cnt   = 0;
    was_stalled = 1'b0;
    hs_tdata    = '0;
    hold_cycles = hold;
    held        = 0;
    tready      = (hold == 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    rxd = 1'b1;
    repeat (100) tick();
    drive_segs();
    rxd = 1'b1;
    repeat (20) tick();
    k = 0;
    while (busy && k < 20000) begin
      tick();
      k++;
    end
    check({name, "/busy_low"}, 32'(busy), 32'd0);
    model(exp_err, exp_p);
    check({name, "/error"}, 32'(error), 32'(exp_err));
    check({name, "/done_count"}, 32'(done_cnt), (exp_err == 3'b000) ? 32'd1 : 32'd0);
    check({name, "/stall_cycles"}, 32'(stall_cnt), (exp_err == 3'b000) ? 32'(hold) : 32'd0);
    if (exp_err == 3'b000) begin
      check({name, "/tdata"}, 32'(hs_tdata), 32'(cfg_word(exp_p)));
      last_good_p = exp_p;
    end
    check({name, "/prescaler"}, 32'(presc), 32'(last_good_p));
  endtask

  initial begin
    int n;
    int k;
    areset   = 1'b1;
    start    = 1'b0;
    rxd      = 1'b1;
    tready   = 1'b1;
    start_t  = 1'b0;
    rxd_t    = 1'b1;
    tready_t = 1'b1;
    repeat (3) tick();
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/tvalid", 32'(tvalid), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/error", 32'(error), 32'd0);
    check("reset/prescaler", 32'(presc), 32'd0);
    check("reset/tdata", 32'(tdata), 32'd0);
    areset = 1'b0;
    tick();

    // Nominal 12 cycles/bit
    clear_segs();
    add_char(8'h55, 12);
    run_case("b12", 0);
    check("b12/word_const", 32'(hs_tdata), 32'h0140000C);

    // 115200 baud at 100 MHz with per-edge jitter; outer falls kept within 0..+3
    clear_segs();
    add_char(8'h55, 868);
    for (int i = 0; i < 9; i++) begin
      if (i == 7) jitter_edge(i, int'($urandom_range(3)));
      else        jitter_edge(i, int'($urandom_range(6)) - 3);
    end
    run_case("b868", 0);
    check("b868/p_const", 32'(presc), 32'd868);

    // Back-pressure: tready low for 5 cycles of tvalid
    clear_segs();
    add_char(8'h55, 12);
    run_case("stall5", 5);

    // Wrong character followed by a sync character
    clear_segs();
    add_char(8'h0F, 12);
    add_char(8'h55, 12);
    run_case("char0f", 0);

    // Two-cycle low glitch inside the first high data bit
    clear_segs();
    add_char(8'h55, 12);
    seg_dur[1] = 4;
    seg_lvl.insert(2, 0);
    seg_dur.insert(2, 2);
    seg_lvl.insert(3, 1);
    seg_dur.insert(3, 6);
    run_case("glitch", 0);

    // Prescaler below minimum
    clear_segs();
    add_char(8'h55, 2);
    run_case("b2_range", 0);

    // Random bit periods with light jitter and random back-pressure
    for (int r = 0; r < 3; r++) begin
      n = int'($urandom_range(40, 6));
      clear_segs();
      add_char(8'h55, n);
      for (int i = 0; i < 9; i++) jitter_edge(i, int'($urandom_range(2)) - 1);
      run_case($sformatf("rand%0d_n%0d", r, n), int'($urandom_range(3)));
    end

    // Reset in the middle of a measurement
    clear_segs();
    add_char(8'h55, 12);
    hold_cycles = 0;
    held = 0;
    tready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    for (int i = 0; i < 3; i++) begin
      rxd = (seg_lvl[i] != 0);
      repeat (seg_dur[i]) tick();
    end
    check("areset/busy_before", 32'(busy), 32'd1);
    areset = 1'b1;
    #1;
    check("areset/busy", 32'(busy), 32'd0);
    check("areset/tvalid", 32'(tvalid), 32'd0);
    check("areset/prescaler", 32'(presc), 32'd0);
    check("areset/error", 32'(error), 32'd0);
    last_good_p = 0;
    rxd = 1'b1;
    tick();
    tick();
    areset = 1'b0;
    tick();
    run_case("after_reset", 0);

    // Timeout instance: line stays high after start
    start_t = 1'b1;
    @(posedge aclk);
    #1;
    start_t = 1'b0;
    check("timeout/busy_start", 32'(busy_t), 32'd1);
    k = 0;
    while (busy_t && k < 3000) begin
      @(posedge aclk);
      #1;
      k++;
    end
    check("timeout/busy", 32'(busy_t), 32'd0);
    check("timeout/error", 32'(error_t), 32'd4);
    check("timeout/window", 32'(k >= 990 && k <= 1010), 32'd1);
    check("timeout/tvalid", 32'(tvalid_t), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
